user_input_conditioner: RTL

- Front-end stage that feeds the 2-bit counter FSM's user_input bus.
- Synchronises the asynchronous raw 3-bit input code and debounces it.
- Presents each confirmed press as exactly one clk cycle of the pressed code on code_out; at all other times code_out holds IDLE_CODE.
- This stops a held input from advancing the downstream FSM on every cycle.

---
 rtl/user_input_conditioner.sv | 133 +++++++++++++
 1 files changed

// File: rtl/user_input_conditioner.sv
// Synchronises, debounces and edge-detects a raw W-bit input code, emitting one pulse per press.
// Define USER_INPUT_CONDITIONER_AUTOREPEAT_EN to add periodic repeat pulses while a code is held.
module user_input_conditioner #(
    parameter int              W               = 3,
    parameter int              DEBOUNCE_CYCLES = 16,
    parameter logic [W-1:0]    IDLE_CODE       = 3'h7,
    parameter int              REPEAT_CYCLES   = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw_in,
    output logic [W-1:0] code_out,
    output logic         code_valid,
    output logic [W-1:0] stable_level
);

    localparam int MAX_CYC = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
`ifdef USER_INPUT_CONDITIONER_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESSED = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t         state;
    logic [W-1:0]   sync_meta;
    logic [W-1:0]   sync;
    logic [W-1:0]   cand;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_inc;

    // Resetting the chain to IDLE_CODE keeps a press from appearing right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= IDLE_CODE;
            sync      <= IDLE_CODE;
        end else begin
            sync_meta <= raw_in;
            sync      <= sync_meta;
        end
    end

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cand         <= IDLE_CODE;
            cnt          <= '0;
            code_out     <= IDLE_CODE;
            code_valid   <= 1'b0;
            stable_level <= IDLE_CODE;
        end else begin
            code_out   <= IDLE_CODE;
            code_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync != IDLE_CODE) begin
                        cand  <= sync;
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (sync == cand) begin
                        if (cnt >= DEB_LAST) begin
                            code_out     <= cand;
                            code_valid   <= 1'b1;
                            stable_level <= cand;
                            cnt          <= '0;
                            state        <= PRESSED;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else if (sync == IDLE_CODE) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cand <= sync;
                        cnt  <= '0;
                    end
                end
                PRESSED: begin
                    if (sync != stable_level) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end
`ifdef USER_INPUT_CONDITIONER_AUTOREPEAT_EN
                    else if (cnt >= REP_LAST) begin
                        code_out   <= stable_level;
                        code_valid <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
`endif
                end
                RELEASE: begin
                    // A short excursion back to the held code is treated as a glitch.
                    if (sync == stable_level) begin
                        cnt   <= '0;
                        state <= PRESSED;
                    end else if (sync == IDLE_CODE) begin
                        if (cnt >= DEB_LAST) begin
                            stable_level <= IDLE_CODE;
                            cnt          <= '0;
                            state        <= IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end else begin
                        cand  <= sync;
                        cnt   <= '0;
                        state <= SETTLE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
